// File: rtl/sync_timing_gen_if.sv
// ---------------------------------------------------------------------------
// sync_timing_gen_if
// Groups the control inputs and timing outputs of sync_timing_gen.
//
// Signal semantics: there is no valid/ready handshake. en and restart are
// level inputs sampled on every rising clock. All timing outputs change
// only on clocks where en is high, and are otherwise stable. px and py are
// meaningful only while disp is high.
//
// Signals:
//   en, restart             : controls, driven by the slave side
//   hs, vs                  : sync outputs, polarity set by the generator
//   de, border, disp        : active-video / border / display-window flags
//   px, py                  : pixel column / line inside the display window
//   line_start, frame_start : single-clock markers
// Modports:
//   master : the timing generator (drives timing, reads controls)
//   slave  : the consumer (drives controls, reads timing)
// ---------------------------------------------------------------------------
interface sync_timing_gen_if #(
    parameter int CW = 12
);
    logic          en;
    logic          restart;
    logic          hs;
    logic          vs;
    logic          de;
    logic          border;
    logic          disp;
    logic [CW-1:0] px;
    logic [CW-1:0] py;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  en, restart,
        output hs, vs, de, border, disp, px, py, line_start, frame_start
    );

    modport slave (
        output en, restart,
        input  hs, vs, de, border, disp, px, py, line_start, frame_start
    );
endinterface

// File: rtl/sync_timing_gen.sv
// ---------------------------------------------------------------------------
// sync_timing_gen
// Raster timing generator. An (x, y) position counter walks the full line
// and frame (active, front porch, sync, back porch). Every output is a
// registered function of that position, so all outputs appear one clock
// after the position they describe and stay mutually aligned.
//
// Ports:
//   clock : pixel clock
//   rst   : asynchronous active-low reset
//   tif   : sync_timing_gen_if.master (en/restart in, timing out)
// ---------------------------------------------------------------------------
module sync_timing_gen #(
    parameter int unsigned XRES     = 640,
    parameter int unsigned XFPORCH  = 16,
    parameter int unsigned XSYNC    = 96,
    parameter int unsigned XBPORCH  = 48,
    parameter int unsigned YRES     = 480,
    parameter int unsigned YFPORCH  = 10,
    parameter int unsigned YSYNC    = 2,
    parameter int unsigned YBPORCH  = 33,
    parameter int unsigned LMARGIN  = 0,
    parameter int unsigned TMARGIN  = 0,
    parameter int unsigned XDISPLAY = 640,
    parameter int unsigned YDISPLAY = 480,
    parameter int unsigned PIXDIV   = 1,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 12
) (
    input  logic               clock,
    input  logic               rst,
    sync_timing_gen_if.master  tif
);
    localparam int unsigned HTOTAL = XRES + XFPORCH + XSYNC + XBPORCH;
    localparam int unsigned VTOTAL = YRES + YFPORCH + YSYNC + YBPORCH;
    localparam int          CWP    = CW + 1;

    // Comparison constants carry one extra bit so a boundary equal to
    // 2^CW still fits.
    localparam logic [CW:0] X_LAST   = CWP'(HTOTAL - 1);
    localparam logic [CW:0] Y_LAST   = CWP'(VTOTAL - 1);
    localparam logic [CW:0] X_ACT    = CWP'(XRES);
    localparam logic [CW:0] Y_ACT    = CWP'(YRES);
    localparam logic [CW:0] HS_START = CWP'(XRES + XFPORCH);
    localparam logic [CW:0] HS_END   = CWP'(XRES + XFPORCH + XSYNC);
    localparam logic [CW:0] VS_START = CWP'(YRES + YFPORCH);
    localparam logic [CW:0] VS_END   = CWP'(YRES + YFPORCH + YSYNC);
    localparam logic [CW:0] WIN_L    = CWP'(LMARGIN);
    localparam logic [CW:0] WIN_R    = CWP'(LMARGIN + XDISPLAY);
    localparam logic [CW:0] WIN_T    = CWP'(TMARGIN);
    localparam logic [CW:0] WIN_B    = CWP'(TMARGIN + YDISPLAY);
    localparam logic [2:0]  PRE_MAX  = 3'(PIXDIV - 1);

    if (LMARGIN + XDISPLAY > XRES) begin : g_bad_xwin
        $error("sync_timing_gen: horizontal window exceeds active width");
    end
    if (TMARGIN + YDISPLAY > YRES) begin : g_bad_ywin
        $error("sync_timing_gen: vertical window exceeds active height");
    end
    if (PIXDIV < 1 || PIXDIV > 8) begin : g_bad_pixdiv
        $error("sync_timing_gen: PIXDIV must be 1..8");
    end
    if (longint'(HTOTAL) > (longint'(1) << CW) ||
        longint'(VTOTAL) > (longint'(1) << CW)) begin : g_bad_cw
        $error("sync_timing_gen: CW too small for HTOTAL/VTOTAL");
    end

    // Position and pixel-prescaler state
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [2:0]    pre_q, pre_d;
    logic [CW-1:0] pxc_q, pxc_d;
    logic          restart_pend_q, restart_pend_d;

    // Registered outputs
    logic          hs_q, hs_d, vs_q, vs_d;
    logic          de_q, de_d, border_q, border_d, disp_q, disp_d;
    logic [CW-1:0] px_q, px_d, py_q, py_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    logic [CW:0] xw, yw;
    logic        x_last, y_last, h_win, v_win, win, act;

    always_comb begin
        xw     = {1'b0, x_q};
        yw     = {1'b0, y_q};
        x_last = (xw == X_LAST);
        y_last = (yw == Y_LAST);
        h_win  = (xw >= WIN_L) && (xw < WIN_R);
        v_win  = (yw >= WIN_T) && (yw < WIN_B);
        win    = h_win && v_win;
        act    = (xw < X_ACT) && (yw < Y_ACT);

        x_d           = x_q;
        y_d           = y_q;
        pre_d         = pre_q;
        pxc_d         = pxc_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        de_d          = de_q;
        border_d      = border_q;
        disp_d        = disp_q;
        px_d          = px_q;
        py_d          = py_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;

        // The latch is consumed at the frame wrap; a request arriving on
        // the wrap clock itself is consumed there too. Counters wrap
        // normally either way, so the frame cadence is undisturbed.
        restart_pend_d = (restart_pend_q || tif.restart) &&
                         !(tif.en && x_last && y_last);

        if (tif.en) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end

            // Prescaler only runs inside the horizontal window and is
            // cleared at each line end, so every line starts at phase 0.
            if (x_last) begin
                pre_d = '0;
                pxc_d = '0;
            end else if (h_win) begin
                if (pre_q == PRE_MAX) begin
                    pre_d = '0;
                    pxc_d = pxc_q + CW'(1);
                end else begin
                    pre_d = pre_q + 3'd1;
                end
            end

            hs_d          = ((xw >= HS_START) && (xw < HS_END)) ? HS_POL : !HS_POL;
            vs_d          = ((yw >= VS_START) && (yw < VS_END)) ? VS_POL : !VS_POL;
            de_d          = act;
            border_d      = act && !win;
            disp_d        = win;
            px_d          = win ? pxc_q : '0;
            py_d          = win ? (y_q - CW'(TMARGIN)) : '0;
            line_start_d  = (x_q == '0);
            frame_start_d = (x_q == '0) && (y_q == '0);
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            x_q            <= '0;
            y_q            <= '0;
            pre_q          <= '0;
            pxc_q          <= '0;
            restart_pend_q <= 1'b0;
            hs_q           <= !HS_POL;
            vs_q           <= !VS_POL;
            de_q           <= 1'b0;
            border_q       <= 1'b0;
            disp_q         <= 1'b0;
            px_q           <= '0;
            py_q           <= '0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            x_q            <= x_d;
            y_q            <= y_d;
            pre_q          <= pre_d;
            pxc_q          <= pxc_d;
            restart_pend_q <= restart_pend_d;
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            de_q           <= de_d;
            border_q       <= border_d;
            disp_q         <= disp_d;
            px_q           <= px_d;
            py_q           <= py_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign tif.hs          = hs_q;
    assign tif.vs          = vs_q;
    assign tif.de          = de_q;
    assign tif.border      = border_q;
    assign tif.disp        = disp_q;
    assign tif.px          = px_q;
    assign tif.py          = py_q;
    assign tif.line_start  = line_start_q;
    assign tif.frame_start = frame_start_q;
endmodule
